// File: rtl/buffer_nxn_hps_to_fpga.sv
// Beat-based loader: scatters two densely packed row-major n x n operand matrices
// into the fixed MAX_DIM x MAX_DIM coprocessor layout and hands them over via valid/ready.
module buffer_nxn_hps_to_fpga #(
    parameter int ELEM_W  = 8,
    parameter int MAX_DIM = 5,
    parameter int BUS_W   = 32,
    parameter int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       dim,
    input  logic             abort,
    input  logic [BUS_W-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [MAT_W-1:0] matrix1_out,
    output logic [MAT_W-1:0] matrix2_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy
);

    localparam int EPB   = BUS_W / ELEM_W;
    localparam int NE    = MAX_DIM * MAX_DIM;
    localparam int IDX_W = $clog2(NE + EPB + 1);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LOAD_A = 2'd1;
    localparam logic [1:0] S_LOAD_B = 2'd2;
    localparam logic [1:0] S_DONE   = 2'd3;

    logic [1:0]       state;
    logic [1:0]       next_state;
    logic [2:0]       n;
    logic [2:0]       dim_clamped;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] nsq;
    logic [NE-1:0]    slot_hit;
    logic [MAT_W-1:0] beat_spread;
    logic [MAT_W-1:0] mat_a;
    logic [MAT_W-1:0] mat_b;
    logic             accept;
    logic             last_beat;

    assign nsq         = IDX_W'(n) * IDX_W'(n);
    assign accept      = in_valid && in_ready && !abort;
    assign last_beat   = (idx + IDX_W'(EPB)) >= nsq;
    assign busy        = (state != S_IDLE);
    assign matrix1_out = mat_a;
    assign matrix2_out = mat_b;

    always_comb begin
        dim_clamped = dim;
        if (dim < 3'd2) begin
            dim_clamped = 3'd2;
        end else if (dim > 3'(MAX_DIM)) begin
            dim_clamped = 3'(MAX_DIM);
        end
    end

    // Each fixed layout slot works out which linear element it holds for the current n,
    // and whether that element arrives in the current beat; no division by n is needed.
    for (genvar s = 0; s < NE; s++) begin : g_slot
        localparam int ROW = s / MAX_DIM;
        localparam int COL = s % MAX_DIM;
        logic [IDX_W-1:0] lin;
        logic [IDX_W-1:0] off;

        assign lin = IDX_W'(ROW) * IDX_W'(n) + IDX_W'(COL);
        assign off = lin - idx;
        assign slot_hit[s] = (IDX_W'(COL) < IDX_W'(n)) && (IDX_W'(ROW) < IDX_W'(n)) &&
                             (lin >= idx) && (off < IDX_W'(EPB)) && (lin < nsq);
        assign beat_spread[MAT_W-1-ELEM_W*s -: ELEM_W] =
            ELEM_W'((in_data << (ELEM_W * off)) >> (BUS_W - ELEM_W));
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:   if (start) next_state = S_LOAD_A;
            S_LOAD_A: if (abort) next_state = S_IDLE;
                      else if (accept && last_beat) next_state = S_LOAD_B;
            S_LOAD_B: if (abort) next_state = S_IDLE;
                      else if (accept && last_beat) next_state = S_DONE;
            S_DONE:   if (abort || out_ready) next_state = S_IDLE;
            default:  next_state = S_IDLE;
        endcase
    end

    // Handshake flags are registered from next_state so they switch on the same edge as the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            n         <= 3'd2;
            idx       <= '0;
            mat_a     <= '0;
            mat_b     <= '0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            state     <= next_state;
            in_ready  <= (next_state == S_LOAD_A) || (next_state == S_LOAD_B);
            out_valid <= (next_state == S_DONE);
            if (state == S_IDLE) begin
                if (start) begin
                    n     <= dim_clamped;
                    idx   <= '0;
                    mat_a <= '0;
                    mat_b <= '0;
                end
            end else if (abort) begin
                idx <= '0;
            end else if (accept) begin
                for (int s = 0; s < NE; s++) begin
                    if (slot_hit[s]) begin
                        if (state == S_LOAD_A) begin
                            mat_a[MAT_W-1-ELEM_W*s -: ELEM_W] <= beat_spread[MAT_W-1-ELEM_W*s -: ELEM_W];
                        end else begin
                            mat_b[MAT_W-1-ELEM_W*s -: ELEM_W] <= beat_spread[MAT_W-1-ELEM_W*s -: ELEM_W];
                        end
                    end
                end
                idx <= last_beat ? '0 : idx + IDX_W'(EPB);
            end
        end
    end

endmodule

// File: tb/tb_buffer_nxn_hps_to_fpga.sv
// Randomized directed bench for buffer_nxn_hps_to_fpga; expected matrices come from
// a row/column placement model of the element lists.
module tb_buffer_nxn_hps_to_fpga;

    localparam int ELEM_W  = 8;
    localparam int MAX_DIM = 5;
    localparam int BUS_W   = 32;
    localparam int MAT_W   = MAX_DIM * MAX_DIM * ELEM_W;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic [2:0]       dim;
    logic             abort;
    logic [BUS_W-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [MAT_W-1:0] matrix1_out;
    logic [MAT_W-1:0] matrix2_out;
    logic             out_valid;
    logic             out_ready;
    logic             busy;

    int checks = 0;
    int failures = 0;
    logic [7:0] el_a [25];
    logic [7:0] el_b [25];
    logic [MAT_W-1:0] hold_a;
    logic [MAT_W-1:0] hold_b;

    buffer_nxn_hps_to_fpga #(
        .ELEM_W(ELEM_W), .MAX_DIM(MAX_DIM), .BUS_W(BUS_W), .MAT_W(MAT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .dim(dim), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .matrix1_out(matrix1_out), .matrix2_out(matrix2_out),
        .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [MAT_W-1:0] obs, input logic [MAT_W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int clamp_dim(input int d);
        return (d < 2) ? 2 : ((d > MAX_DIM) ? MAX_DIM : d);
    endfunction

    // Element k of an n x n matrix sits at row k/n, column k%n of the MAX_DIM grid.
    function automatic logic [MAT_W-1:0] model_matrix(input int n, input int count, input bit use_b);
        logic [MAT_W-1:0] m = '0;
        for (int k = 0; k < n * n && k < count; k++) begin
            m[MAT_W-1-ELEM_W*(MAX_DIM*(k/n)+(k%n)) -: ELEM_W] = use_b ? el_b[k] : el_a[k];
        end
        return m;
    endfunction

    // Beat b of the whole transfer; matrix B begins on a fresh beat, padding is random junk.
    function automatic logic [BUS_W-1:0] make_beat(input int b, input int n);
        logic [BUS_W-1:0] beat = '0;
        int nn = n * n;
        int bpm = (nn + 3) / 4;
        bit second = (b >= bpm);
        int j = second ? b - bpm : b;
        for (int k = 0; k < 4; k++) begin
            int e = j * 4 + k;
            if (e < nn) beat[BUS_W-1-8*k -: 8] = second ? el_b[e] : el_a[e];
            else        beat[BUS_W-1-8*k -: 8] = 8'($urandom);
        end
        return beat;
    endfunction

    task automatic fill_random();
        for (int i = 0; i < 25; i++) begin
            el_a[i] = 8'($urandom);
            el_b[i] = 8'($urandom);
        end
    endtask

    // gap_mode: 0 = back-to-back beats, 1 = in_valid every other cycle, 2 = random gaps.
    task automatic apply_stimulus(input int dim_in, input int gap_mode);
        int n = clamp_dim(dim_in);
        int total = 2 * ((n * n + 3) / 4);
        int b = 0;
        int cyc = 0;
        bit v;
        start = 1'b1;
        dim   = 3'(dim_in);
        @(posedge clk); #1;
        start = 1'b0;
        while (b < total && cyc < 400) begin
            v = (gap_mode == 0) ? 1'b1 : ((gap_mode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1)));
            check_output("load_handshake", {in_ready, out_valid}, 2'b10);
            in_valid = v;
            in_data  = make_beat(b, n);
            @(posedge clk); #1;
            if (v) b++;
            cyc++;
        end
        in_valid = 1'b0;
        check_output("beat_budget", b, total);
        check_output("done_handshake", {in_ready, out_valid, busy}, 3'b011);
        check_output("matrix_a", matrix1_out, model_matrix(n, 25, 1'b0));
        check_output("matrix_b", matrix2_out, model_matrix(n, 25, 1'b1));
    endtask

    task automatic finish_done();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output("release_idle", {in_ready, out_valid, busy}, 3'b000);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; dim = 3'd0; abort = 1'b0;
        in_data = '0; in_valid = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset_flags", {in_ready, out_valid, busy}, 3'b000);
        check_output("reset_m1", matrix1_out, '0);
        check_output("reset_m2", matrix2_out, '0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        $display("[TB] n=4 directed load");
        for (int i = 0; i < 25; i++) begin
            el_a[i] = 8'(i + 1);
            el_b[i] = 8'hFF;
        end
        apply_stimulus(4, 0);
        check_output("n4_row0", matrix1_out[199:168], 32'h01020304);
        check_output("n4_row1", matrix1_out[159:128], 32'h05060708);
        check_output("n4_pad", {matrix1_out[167:160], matrix1_out[127:120], matrix1_out[87:80], matrix1_out[47:0]}, '0);
        check_output("n4_b_row0", matrix2_out[199:168], 32'hFFFFFFFF);
        finish_done();

        $display("[TB] n=5 load with discarded tail bytes");
        for (int i = 0; i < 25; i++) el_a[i] = 8'(i + 1);
        for (int i = 0; i < 25; i++) el_b[i] = 8'($urandom);
        apply_stimulus(5, 0);
        check_output("n5_last", matrix1_out[7:0], 8'd25);
        finish_done();

        $display("[TB] n=2 with toggling valid, then DONE hold");
        fill_random();
        apply_stimulus(2, 1);
        check_output("n2_zero", {matrix1_out[183:160], matrix1_out[143:0]}, '0);
        hold_a = model_matrix(2, 25, 1'b0);
        hold_b = model_matrix(2, 25, 1'b1);
        for (int i = 0; i < 10; i++) begin
            start = 1'b1;
            dim   = 3'($urandom);
            @(posedge clk); #1;
            check_output("hold_flags", {in_ready, out_valid, busy}, 3'b011);
            check_output("hold_m1", matrix1_out, hold_a);
            check_output("hold_m2", matrix2_out, hold_b);
        end
        start = 1'b0;
        finish_done();

        $display("[TB] abort on third beat of n=3");
        fill_random();
        start = 1'b1; dim = 3'd3;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 3; b++) begin
            in_valid = 1'b1;
            in_data  = make_beat(b, 3);
            abort    = (b == 2);
            @(posedge clk); #1;
        end
        abort = 1'b0; in_valid = 1'b0;
        check_output("abort_flags", {in_ready, out_valid, busy}, 3'b000);
        check_output("abort_m1", matrix1_out, model_matrix(3, 8, 1'b0));
        @(posedge clk); #1;
        check_output("abort_quiet", {in_ready, out_valid, busy}, 3'b000);

        $display("[TB] dim=7 clamps to 5, random gaps");
        fill_random();
        apply_stimulus(7, 2);
        finish_done();

        $display("[TB] dim=1 clamps to 2, random gaps");
        fill_random();
        apply_stimulus(1, 2);
        finish_done();

        $display("[TB] reset during LOAD_B");
        fill_random();
        start = 1'b1; dim = 3'd4;
        @(posedge clk); #1;
        start = 1'b0;
        for (int b = 0; b < 5; b++) begin
            in_valid = 1'b1;
            in_data  = make_beat(b, 4);
            @(posedge clk); #1;
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_output("async_rst_flags", {in_ready, out_valid, busy}, 3'b000);
        check_output("async_rst_m1", matrix1_out, '0);
        check_output("async_rst_m2", matrix2_out, '0);
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        fill_random();
        apply_stimulus(3, 0);
        finish_done();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/buffer_nxn_hps_to_fpga.md
# buffer_nxn_hps_to_fpga

Sequential, size-parametrised loader that receives two densely packed, row-major operand matrices from the HPS over a narrow beat-based bus. It scatters each element into the fixed MAX_DIM×MAX_DIM coprocessor layout and zero-fills unused positions. When both matrices are complete it presents them to the arithmetic core through a valid/ready handshake. It sits between the HPS bridge registers and the matrix ALU and replaces the fixed 4×4 combinational reorganiser.

## Interface
- ELEM_W, 8, element width in bits
- MAX_DIM, 5, largest supported matrix dimension
- BUS_W, 32, input beat width; EPB = BUS_W/ELEM_W elements per beat; BUS_W must be a multiple of ELEM_W
- MAT_W, MAX_DIM*MAX_DIM*ELEM_W (200), flattened matrix width
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load; sampled only in IDLE
- dim  in  3  matrix dimension n, sampled with start
- abort  in  1  synchronous cancel of the load in progress
- in_data  in  BUS_W  packed elements; first element in the MS ELEM_W bits
- in_valid  in  1  in_data valid
- in_ready  out  1  beat accepted when in_valid & in_ready
- matrix1_out, matrix2_out  out  MAT_W  organised matrices A and B
- out_valid  out  1  both matrices complete and stable
- out_ready  in  1  consumer accepts the pair
- busy  out  1  state ≠ IDLE

## Operation
- Layout: element (r,c) of an n×n matrix goes to bits [MAT_W-1-ELEM_W*(MAX_DIM*r+c) -: ELEM_W]. All positions with r≥n or c≥n are 0.
- dim clamping: dim<2 → 2; dim>MAX_DIM → MAX_DIM. The latched value is n.
- Per-matrix element count N=n². Beats per matrix = ceil(N/EPB). Each matrix starts on a fresh beat. Surplus elements of the last beat are discarded.
- States: IDLE, LOAD_A, LOAD_B, DONE.
  - IDLE: in_ready=0. On start: latch n, clear both matrices to 0, clear element index idx, go to LOAD_A.
  - LOAD_A/LOAD_B: in_ready=1. On each accepted beat, write elements idx..min(idx+EPB,N)-1 into the current matrix, then set idx+=EPB. If idx+EPB≥N, set idx=0 and advance to LOAD_B (from LOAD_A) or DONE (from LOAD_B).
  - DONE: out_valid=1. Outputs are held. When out_ready=1, go to IDLE. The matrices keep their contents until the next start.
- start outside IDLE is ignored.
- abort in LOAD_A/LOAD_B/DONE: go to IDLE, clear idx and out_valid. abort takes priority over a simultaneous beat or out_ready. Matrix contents are not cleared by abort.
- Reset mid-operation: all state returns to reset values immediately (asynchronous reset).
- Reset values: state=IDLE, in_ready=0, out_valid=0, busy=0, matrix1_out=0, matrix2_out=0, idx=0, n=2.

## Timing
- start accepted at edge k → in_ready=1 from cycle k+1.
- Beats are accepted on consecutive cycles. Throughput is 1 beat/cycle with no bubbles, including the A→B transition.
- Last B beat accepted at edge m → out_valid=1 and in_ready=0 from cycle m+1.
- out_valid & out_ready at edge j → out_valid=0 and busy=0 from cycle j+1. A start is accepted no earlier than edge j+1.
- Matrix outputs update on the same edge as the accepting beat. Their values are meaningful only while out_valid=1.
- in_ready and out_valid are registered and are never high together.
- Load lengths with EPB=4:
  - n=2: 1 beat per matrix
  - n=3: 3 beats per matrix
  - n=4: 4 beats per matrix
  - n=5: 7 beats per matrix

## Test plan
- n=4: A beats 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10; B all 0xFF → matrix1_out[199:168]=0x01020304, [159:128]=0x05060708; bytes [167:160], [127:120], [87:80] and [47:0]=0; matrix2_out row bytes 0xFF. out_valid rises 1 cycle after the 8th beat.
- n=5: 7 beats each, elements 1..25 → element 25 at bits [7:0]. The three trailing bytes of beat 7 are discarded, and matrix B starts with the first byte of beat 8.
- n=2 with in_valid toggling every other cycle → exactly 2 accepted beats. matrix1_out[199:184]=first two bytes, [159:144]=next two bytes, all other bits 0.
- out_ready held low 10 cycles in DONE → out_valid stays 1, outputs stable, in_ready=0, start ignored. out_ready=1 → IDLE next cycle.
- abort asserted together with the 3rd beat of A (n=3) → beat not written, IDLE next cycle, out_valid never rises. Next start with dim=7 clamps to n=5 and needs 14 beats.
- rst_n low mid-LOAD_B → all outputs 0 asynchronously. After release, a fresh n=3 load completes normally.
